// File: rtl/ring_phase_monitor_if.sv
// Phase-monitor bus: ring-counter inputs and monitor status outputs.
// slave = monitor side, master = driver/observer side.
interface ring_phase_monitor_if #(
    parameter int N  = 4,
    parameter int IW = 2,
    parameter int CW = 8
);
    logic          en;
    logic [N-1:0]  phase;
    logic          clr_fault;
    logic [IW-1:0] idx;
    logic          valid;
    logic          sof;
    logic          locked;
    logic          fault;
    logic [1:0]    fault_code;
    logic [CW-1:0] rot_cnt;

    modport master (
        output en, phase, clr_fault,
        input  idx, valid, sof, locked, fault, fault_code, rot_cnt
    );

    modport slave (
        input  en, phase, clr_fault,
        output idx, valid, sof, locked, fault, fault_code, rot_cnt
    );
endinterface

// File: rtl/ring_phase_monitor.sv
// Ring-counter phase checker: index encode, sof pulse, lock and fault FSM.
// Define RINGMON_ROTCNT_EN to build the rotation counter (else rot_cnt = 0).
module ring_phase_monitor #(
    parameter int N        = 4,
    parameter int IW       = 2,
    parameter int CW       = 8,
    parameter int LOCK_ROT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ring_phase_monitor_if.slave  bus
);
    localparam int WW = (LOCK_ROT < 1) ? 1 : $clog2(LOCK_ROT + 1);

    typedef enum logic [1:0] {
        S_ACQ, S_TRACK, S_LOCK, S_FAULT
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  phase_q;
    logic          en_q;
    logic [WW-1:0] wrap_q, wrap_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          sof_q, sof_d;
    logic [1:0]    code_q, code_d;

    logic          onehot;
    logic          consist;
    logic          wrap;
    logic          lock_hit;
    logic [N-1:0]  exp_ph;
    logic [IW-1:0] enc;

    always_comb begin
        onehot   = $onehot(bus.phase);
        exp_ph   = en_q ? {phase_q[N-2:0], phase_q[N-1]} : phase_q;
        consist  = onehot && (bus.phase == exp_ph);
        wrap     = consist && en_q && bus.phase[0];
        lock_hit = wrap && (wrap_q == WW'(LOCK_ROT - 1));
    end

    always_comb begin
        enc = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.phase[i]) enc = enc | IW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        wrap_d  = wrap_q;
        idx_d   = idx_q;
        valid_d = onehot;
        sof_d   = 1'b0;
        code_d  = code_q;
        if (onehot && state_q != S_FAULT) idx_d = enc;
        unique case (state_q)
            S_ACQ: begin
                if (onehot) begin
                    state_d = S_TRACK;
                    wrap_d  = '0;
                end
            end
            S_TRACK: begin
                if (!consist) begin
                    state_d = S_ACQ;
                end else if (wrap) begin
                    sof_d  = 1'b1;
                    wrap_d = wrap_q + 1'b1;
                    if (lock_hit) state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                // Fault code priority: shape, then motion without enable, then step.
                if (!consist) begin
                    state_d = S_FAULT;
                    if (!onehot)    code_d = 2'b01;
                    else if (!en_q) code_d = 2'b11;
                    else            code_d = 2'b10;
                end else if (wrap) begin
                    sof_d = 1'b1;
                end
            end
            S_FAULT: begin
                if (bus.clr_fault) begin
                    state_d = S_ACQ;
                    code_d  = 2'b00;
                end
            end
            default: state_d = S_ACQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACQ;
            phase_q <= '0;
            en_q    <= 1'b0;
            wrap_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            phase_q <= bus.phase;
            en_q    <= bus.en;
            wrap_q  <= wrap_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            code_q  <= code_d;
        end
    end

`ifdef RINGMON_ROTCNT_EN
    logic [CW-1:0] rot_q, rot_d;

    always_comb begin
        rot_d = rot_q;
        if (state_q == S_TRACK && lock_hit) rot_d = '0;
        else if (state_q == S_LOCK && wrap) rot_d = rot_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rot_q <= '0;
        else        rot_q <= rot_d;
    end

    assign bus.rot_cnt = rot_q;
`else
    assign bus.rot_cnt = '0;
`endif

    assign bus.idx        = idx_q;
    assign bus.valid      = valid_q;
    assign bus.sof        = sof_q;
    assign bus.locked     = (state_q == S_LOCK);
    assign bus.fault      = (state_q == S_FAULT);
    assign bus.fault_code = code_q;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor (N=4, IW=2, CW=8, LOCK_ROT=1).
// Reference model works on phase indices; a monitor pops and compares.
module tb_ring_phase_monitor;
    logic clk;
    logic rst_n;

    ring_phase_monitor_if #(.N(4), .IW(2), .CW(8)) bus ();

    ring_phase_monitor #(
        .N(4), .IW(2), .CW(8), .LOCK_ROT(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] idx;
        logic       valid;
        logic       sof;
        logic       locked;
        logic       fault;
        logic [1:0] code;
        logic [7:0] rot;
    } exp_t;

    typedef enum {M_ACQ, M_TRK, M_LCK, M_FLT} mst_e;

    exp_t q[$];
    int   npass  = 0;
    int   ntotal = 0;

    mst_e       m_st;
    logic [3:0] m_prev;
    logic       m_en1;
    int         m_wraps;
    logic [1:0] m_idx;
    logic       m_valid;
    logic       m_sof;
    logic [1:0] m_code;
    int         m_rot;

    function automatic int idx_of(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [3:0] vec_of(input int k);
        logic [3:0] t;
        t = 4'b0001;
        return t << (k % 4);
    endfunction

    task automatic check(input exp_t e);
        bit ok;
        ntotal++;
        ok = (bus.idx === e.idx) && (bus.valid === e.valid) &&
             (bus.sof === e.sof) && (bus.locked === e.locked) &&
             (bus.fault === e.fault) && (bus.fault_code === e.code) &&
             (bus.rot_cnt === e.rot);
        if (ok) npass++;
        else $display("FAIL %s: got i%0h v%0b s%0b l%0b f%0b c%0h r%0d want i%0h v%0b s%0b l%0b f%0b c%0h r%0d",
                      e.tag, bus.idx, bus.valid, bus.sof, bus.locked,
                      bus.fault, bus.fault_code, bus.rot_cnt,
                      e.idx, e.valid, e.sof, e.locked, e.fault, e.code, e.rot);
    endtask

    task automatic chk_val(input string tag, input int act, input int req);
        ntotal++;
        if (act == req) npass++;
        else $display("FAIL %s: got %0d want %0d", tag, act, req);
    endtask

    function automatic exp_t model_out(input string tag);
        exp_t e;
        e.tag    = tag;
        e.idx    = m_idx;
        e.valid  = m_valid;
        e.sof    = m_sof;
        e.locked = (m_st == M_LCK);
        e.fault  = (m_st == M_FLT);
        e.code   = m_code;
`ifdef RINGMON_ROTCNT_EN
        e.rot    = 8'(m_rot);
`else
        e.rot    = 8'd0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        m_st = M_ACQ; m_prev = 4'b0; m_en1 = 1'b0; m_wraps = 0;
        m_idx = 2'b0; m_valid = 1'b0; m_sof = 1'b0;
        m_code = 2'b0; m_rot = 0;
    endtask

    task automatic model_step(input logic e, input logic [3:0] ph,
                              input logic clr, input string tag);
        bit oh, cons, wr;
        logic [3:0] ev;
        oh = ($countones(ph) == 1);
        ev = m_prev;
        if (m_en1 && $countones(m_prev) == 1)
            ev = vec_of(idx_of(m_prev) + 1);
        cons = oh && (ph == ev);
        wr   = cons && m_en1 && ph[0];
        m_sof = 1'b0;
        if (oh && m_st != M_FLT) m_idx = 2'(idx_of(ph));
        case (m_st)
            M_ACQ: if (oh) begin m_st = M_TRK; m_wraps = 0; end
            M_TRK: begin
                if (!cons) m_st = M_ACQ;
                else if (wr) begin
                    m_sof = 1'b1;
                    m_wraps++;
                    if (m_wraps == 1) begin m_st = M_LCK; m_rot = 0; end
                end
            end
            M_LCK: begin
                if (!cons) begin
                    m_st = M_FLT;
                    m_code = !oh ? 2'b01 : (!m_en1 ? 2'b11 : 2'b10);
                end else if (wr) begin
                    m_sof = 1'b1;
                    m_rot = (m_rot + 1) % 256;
                end
            end
            M_FLT: if (clr) begin m_st = M_ACQ; m_code = 2'b00; end
        endcase
        m_valid = oh;
        m_prev  = ph;
        m_en1   = e;
        q.push_back(model_out(tag));
    endtask

    // Called at a negedge; drives inputs for the next rising edge.
    task automatic step(input logic e, input logic [3:0] ph,
                        input logic clr, input string tag);
        bus.en = e; bus.phase = ph; bus.clr_fault = clr;
        model_step(e, ph, clr, tag);
        @(negedge clk);
    endtask

    task automatic rotate(input int n, input string tag);
        for (int i = 0; i < 4 * n; i++)
            step(1'b1, {m_prev[2:0], m_prev[3]}, 1'b0, tag);
    endtask

    task automatic relock(input string tag);
        step(1'b0, 4'b0001, 1'b0, tag);
        step(1'b1, 4'b0001, 1'b0, tag);
        step(1'b1, 4'b0010, 1'b0, tag);
        step(1'b1, 4'b0100, 1'b0, tag);
        step(1'b1, 4'b1000, 1'b0, tag);
        step(1'b1, 4'b0001, 1'b0, tag);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e);
            end
        end
    end

    initial begin
        logic [3:0] ph;
        logic       en_r;
        int         r;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.phase = 4'b0; bus.clr_fault = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check(model_out("reset"));
        rst_n = 1'b1;

        repeat (10) step(1'b0, 4'b0001, 1'b0, "t1_idle");
        chk_val("t1_valid", bus.valid, 1);
        chk_val("t1_locked", bus.locked, 0);

        relock("t2_lock");
        chk_val("t2_sof", bus.sof, 1);
        chk_val("t2_locked", bus.locked, 1);
        rotate(2, "t2_rot");

        step(1'b0, 4'b0110, 1'b0, "t3_bad");
        chk_val("t3_code", bus.fault_code, 1);
        repeat (5) step(1'b0, 4'($urandom_range(0, 15)), 1'b0, "t3_hold");
        step(1'b0, 4'b0001, 1'b1, "t3_clr");
        chk_val("t3_fault", bus.fault, 0);

        relock("t4a_lock");
        step(1'b1, 4'b0010, 1'b0, "t4a_ok");
        step(1'b1, 4'b1000, 1'b0, "t4a_skip");
        chk_val("t4a_code", bus.fault_code, 2);
        step(1'b0, 4'b0001, 1'b1, "t4a_clr");

        relock("t4b_lock");
        step(1'b0, 4'b0010, 1'b0, "t4b_ok");
        step(1'b0, 4'b0100, 1'b0, "t4b_move");
        chk_val("t4b_code", bus.fault_code, 3);
        step(1'b0, 4'b0001, 1'b1, "t4b_clr");

        relock("t5_lock");
        rotate(300, "t5_rot");
`ifdef RINGMON_ROTCNT_EN
        chk_val("t5_rot_cnt", bus.rot_cnt, 44);
`else
        chk_val("t5_rot_cnt", bus.rot_cnt, 0);
`endif

        step(1'b1, 4'b0010, 1'b0, "t6_pre");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 model_reset();
        check(model_out("t6_async_rst"));
        @(negedge clk);
        rst_n = 1'b1;
        relock("t6_relock");
        chk_val("t6_locked", bus.locked, 1);

        for (int i = 0; i < 600; i++) begin
            r    = $urandom_range(0, 99);
            en_r = ($urandom_range(0, 9) < 7);
            if (r < 4)
                ph = 4'($urandom_range(0, 15));
            else if (r < 7 || $countones(m_prev) != 1)
                ph = vec_of($urandom_range(0, 3));
            else
                ph = m_en1 ? vec_of(idx_of(m_prev) + 1) : m_prev;
            step(en_r, ph, ($urandom_range(0, 9) == 0), "rand");
        end

        repeat (2) @(negedge clk);
        chk_val("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
